// File: rtl/fetch_pc_seq_if.sv
// Fetch-PC sequencer bundle interface: redirect/stall/ready inputs and the
// fetch bundle (valid, start PC, count) handed to the I-cache select stage.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

interface fetch_pc_seq_if;
  logic                redirect_i;
  logic [`SIZE_PC-1:0] redirectPC_i;
  logic                stall_i;
  logic                fetchReady_i;
  logic                fetchValid_o;
  logic [`SIZE_PC-1:0] fetchPC_o;
  logic [2:0]          fetchCount_o;

  modport master (
    input  redirect_i, redirectPC_i, stall_i, fetchReady_i,
    output fetchValid_o, fetchPC_o, fetchCount_o
  );

  modport slave (
    output redirect_i, redirectPC_i, stall_i, fetchReady_i,
    input  fetchValid_o, fetchPC_o, fetchCount_o
  );
endinterface

// File: rtl/fetch_pc_seq.sv
// Fetch PC sequencer (BOOT/RUN/BUBBLE). Define FETCH_ALIGN_EN to shorten
// bundles after an unaligned redirect so later bundles land on FETCH_WIDTH boundaries.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

module fetch_pc_seq #(
  parameter logic [`SIZE_PC-1:0] RESET_PC    = 32'h0000_1000,
  parameter int                  FETCH_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_seq_if.master bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  localparam logic [2:0]          FW3         = 3'(FETCH_WIDTH);
  localparam logic [`SIZE_PC-1:0] PC_MASK     = {{(`SIZE_PC-2){1'b1}}, 2'b00};
  localparam logic [`SIZE_PC-1:0] RESET_PC_AL = RESET_PC & PC_MASK;

  state_t              r_state;
  logic [`SIZE_PC-1:0] r_pc;
  logic [2:0]          r_count;
  logic [`SIZE_PC-1:0] w_pc_nxt;
  logic [`SIZE_PC-1:0] w_redir_pc;
  logic                w_valid;
  logic                w_xfer;

`ifdef FETCH_ALIGN_EN
  // Instructions left before the next FETCH_WIDTH-aligned boundary.
  function automatic logic [2:0] calc_count(input logic [`SIZE_PC-1:0] pc);
    case (FETCH_WIDTH)
      2:       calc_count = FW3 - {2'b00, pc[2]};
      4:       calc_count = FW3 - {1'b0, pc[3:2]};
      default: calc_count = FW3;
    endcase
  endfunction
`endif

  assign w_redir_pc = bus.redirectPC_i & PC_MASK;
  assign w_valid    = (r_state == RUN) && !bus.stall_i;
  assign w_xfer     = w_valid && bus.fetchReady_i;

  assign bus.fetchValid_o = w_valid;
  assign bus.fetchPC_o    = r_pc;
  assign bus.fetchCount_o = r_count;

  // Redirect wins over everything; otherwise pc only moves on a transfer.
  always_comb begin
    w_pc_nxt = r_pc;
    if (bus.redirect_i) begin
      w_pc_nxt = w_redir_pc;
    end else if (w_xfer) begin
      w_pc_nxt = r_pc + `SIZE_PC'({r_count, 2'b00});
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC_AL;
      r_count <= FW3;
    end else begin
      r_pc <= w_pc_nxt;
`ifdef FETCH_ALIGN_EN
      r_count <= calc_count(w_pc_nxt);
`else
      r_count <= FW3;
`endif
      if (bus.redirect_i) begin
        r_state <= BUBBLE;
      end else begin
        case (r_state)
          BOOT:    r_state <= RUN;
          RUN:     r_state <= RUN;
          BUBBLE:  r_state <= RUN;
          default: r_state <= BOOT;
        endcase
      end
    end
  end

endmodule
